// File: rtl/ibuf_warp_queue.sv
// Per-warp instruction buffer: collapsing in-order queue between ID and issue.
// Entry 0 is always the oldest. Each entry holds a payload, three register tags
// and a sticky ready bit. Oldest-ready-first selection, flush, overflow flag.
module ibuf_warp_queue #(
    parameter int DEPTH       = 4,
    parameter int PAYLOAD_W   = 48,
    parameter int TAG_W       = 6,
    parameter bit WR_ON_ISSUE = 1'b0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_wr_en,
    input  logic [PAYLOAD_W-1:0]         i_wr_payload,
    input  logic [TAG_W-1:0]             i_wr_src1,
    input  logic [TAG_W-1:0]             i_wr_src2,
    input  logic [TAG_W-1:0]             i_wr_dst,
    input  logic                         i_flush,
    input  logic [DEPTH-1:0]             i_sb_ready,
    input  logic                         i_sb_full,
    input  logic                         i_issue_grant,
    output logic                         o_issue_req,
    output logic [PAYLOAD_W-1:0]         o_issue_payload,
    output logic [TAG_W-1:0]             o_issue_src1,
    output logic [TAG_W-1:0]             o_issue_src2,
    output logic [TAG_W-1:0]             o_issue_dst,
    output logic [DEPTH-1:0]             o_issued_onehot,
    output logic [DEPTH-1:0]             o_ent_valid,
    output logic [DEPTH*TAG_W-1:0]       o_ent_src1,
    output logic [DEPTH*TAG_W-1:0]       o_ent_src2,
    output logic [DEPTH*TAG_W-1:0]       o_ent_dst,
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
    output logic                         o_full,
    output logic                         o_empty,
    output logic                         o_overflow
);

    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    if (DEPTH < 2) begin : g_depth_check
        $error("ibuf_warp_queue: DEPTH must be at least 2");
    end

    logic [PAYLOAD_W-1:0] r_payload [DEPTH];
    logic [TAG_W-1:0]     r_src1    [DEPTH];
    logic [TAG_W-1:0]     r_src2    [DEPTH];
    logic [TAG_W-1:0]     r_dst     [DEPTH];
    logic [DEPTH-1:0]     r_ready;
    logic [CNT_W-1:0]     r_count;
    logic                 r_overflow;

    logic [PAYLOAD_W-1:0] w_nxt_payload [DEPTH];
    logic [TAG_W-1:0]     w_nxt_src1    [DEPTH];
    logic [TAG_W-1:0]     w_nxt_src2    [DEPTH];
    logic [TAG_W-1:0]     w_nxt_dst     [DEPTH];
    logic [PAYLOAD_W-1:0] w_up_payload  [DEPTH];
    logic [TAG_W-1:0]     w_up_src1     [DEPTH];
    logic [TAG_W-1:0]     w_up_src2     [DEPTH];
    logic [TAG_W-1:0]     w_up_dst      [DEPTH];
    logic [DEPTH-1:0]     w_up_ready;
    logic [DEPTH-1:0]     w_nxt_ready;
    logic [DEPTH-1:0]     w_rdy_upd;
    logic [DEPTH-1:0]     w_valid;
    logic [DEPTH-1:0]     w_rdy_vld;
    logic [CNT_W-1:0]     w_nxt_count;
    logic [CNT_W-1:0]     w_wpos;
    logic [IDX_W-1:0]     w_sel;
    logic                 w_full;
    logic                 w_issue_req;
    logic                 w_fire;
    logic                 w_wr_acc;
    logic                 w_wr_drop;

    // Valid is thermometer-coded from the occupancy count; selection of the oldest ready entry.
    always_comb begin
        w_valid = '0;
        w_sel   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_valid[i] = (CNT_W'(i) < r_count);
        end
        w_rdy_vld = w_valid & r_ready;
        for (int i = DEPTH-1; i >= 0; i--) begin
            if (w_rdy_vld[i]) begin
                w_sel = IDX_W'(i);
            end
        end
    end

    assign w_full      = (r_count == CNT_W'(DEPTH));
    assign w_issue_req = (|w_rdy_vld) && !i_sb_full && !i_flush;
    assign w_fire      = w_issue_req && i_issue_grant;
    assign w_wr_acc    = i_wr_en && !i_flush && (!w_full || (WR_ON_ISSUE && w_fire));
    assign w_wr_drop   = i_wr_en && !i_flush && !w_wr_acc;
    assign w_wpos      = r_count - CNT_W'(w_fire);

    // Next-state of the entry array: ready update, collapse above the issued slot, then the write.
    always_comb begin
        w_rdy_upd = r_ready | (i_sb_ready & w_valid);
        for (int i = 0; i < DEPTH-1; i++) begin
            w_up_payload[i] = r_payload[i+1];
            w_up_src1[i]    = r_src1[i+1];
            w_up_src2[i]    = r_src2[i+1];
            w_up_dst[i]     = r_dst[i+1];
            w_up_ready[i]   = w_rdy_upd[i+1];
        end
        w_up_payload[DEPTH-1] = '0;
        w_up_src1[DEPTH-1]    = '0;
        w_up_src2[DEPTH-1]    = '0;
        w_up_dst[DEPTH-1]     = '0;
        w_up_ready[DEPTH-1]   = 1'b0;

        for (int i = 0; i < DEPTH; i++) begin
            w_nxt_payload[i] = r_payload[i];
            w_nxt_src1[i]    = r_src1[i];
            w_nxt_src2[i]    = r_src2[i];
            w_nxt_dst[i]     = r_dst[i];
            w_nxt_ready[i]   = w_rdy_upd[i];
            if (w_fire && (IDX_W'(i) >= w_sel)) begin
                w_nxt_payload[i] = w_up_payload[i];
                w_nxt_src1[i]    = w_up_src1[i];
                w_nxt_src2[i]    = w_up_src2[i];
                w_nxt_dst[i]     = w_up_dst[i];
                w_nxt_ready[i]   = w_up_ready[i];
            end
            if (w_wr_acc && (CNT_W'(i) == w_wpos)) begin
                w_nxt_payload[i] = i_wr_payload;
                w_nxt_src1[i]    = i_wr_src1;
                w_nxt_src2[i]    = i_wr_src2;
                w_nxt_dst[i]     = i_wr_dst;
                w_nxt_ready[i]   = 1'b0;
            end
        end

        if (i_flush) begin
            w_nxt_ready = '0;
            w_nxt_count = '0;
        end else begin
            w_nxt_count = r_count + CNT_W'(w_wr_acc) - CNT_W'(w_fire);
        end
    end

    // Entry storage, ready bits, occupancy and sticky overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_payload[i] <= '0;
                r_src1[i]    <= '0;
                r_src2[i]    <= '0;
                r_dst[i]     <= '0;
            end
            r_ready    <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                r_payload[i] <= w_nxt_payload[i];
                r_src1[i]    <= w_nxt_src1[i];
                r_src2[i]    <= w_nxt_src2[i];
                r_dst[i]     <= w_nxt_dst[i];
            end
            r_ready <= w_nxt_ready;
            r_count <= w_nxt_count;
            if (w_wr_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Flattened per-entry tags for the scoreboard.
    always_comb begin
        o_ent_src1 = '0;
        o_ent_src2 = '0;
        o_ent_dst  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            o_ent_src1[i*TAG_W +: TAG_W] = r_src1[i];
            o_ent_src2[i*TAG_W +: TAG_W] = r_src2[i];
            o_ent_dst[i*TAG_W +: TAG_W]  = r_dst[i];
        end
    end

    assign o_issue_req     = w_issue_req;
    assign o_issue_payload = r_payload[w_sel];
    assign o_issue_src1    = r_src1[w_sel];
    assign o_issue_src2    = r_src2[w_sel];
    assign o_issue_dst     = r_dst[w_sel];
    assign o_issued_onehot = w_fire ? ({{(DEPTH-1){1'b0}}, 1'b1} << w_sel) : '0;
    assign o_ent_valid     = w_valid;
    assign o_count         = r_count;
    assign o_full          = w_full;
    assign o_empty         = (r_count == '0);
    assign o_overflow      = r_overflow;

endmodule

// File: tb/tb_ibuf_warp_queue.sv
// Scoreboard bench for ibuf_warp_queue: two instances (WR_ON_ISSUE = 0 and 1)
// share one directed stimulus stream; expected issues are queued and popped by
// a monitor whenever an instance fires an issue.
module tb_ibuf_warp_queue;

    localparam int DEPTH = 4;
    localparam int PW    = 48;
    localparam int TW    = 6;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic i_wr_en = 1'b0;
    logic [PW-1:0] i_wr_payload = '0;
    logic [TW-1:0] i_wr_src1 = '0, i_wr_src2 = '0, i_wr_dst = '0;
    logic i_flush = 1'b0;
    logic [DEPTH-1:0] i_sb_ready = '0;
    logic i_sb_full = 1'b0;
    logic i_issue_grant = 1'b0;

    logic             req0, req1;
    logic [PW-1:0]    pay0, pay1;
    logic [TW-1:0]    s1_0, s1_1, s2_0, s2_1, d_0, d_1;
    logic [DEPTH-1:0] oh0, oh1, ev0, ev1;
    logic [DEPTH*TW-1:0] es1_0, es1_1, es2_0, es2_1, ed_0, ed_1;
    logic [2:0]       cnt0, cnt1;
    logic             full0, full1, empty0, empty1, ovf0, ovf1;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [DEPTH-1:0] oh;
        logic [PW-1:0]    pay;
    } exp_t;
    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;

    ibuf_warp_queue #(.DEPTH(DEPTH), .PAYLOAD_W(PW), .TAG_W(TW), .WR_ON_ISSUE(1'b0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .i_wr_en(i_wr_en), .i_wr_payload(i_wr_payload),
        .i_wr_src1(i_wr_src1), .i_wr_src2(i_wr_src2), .i_wr_dst(i_wr_dst),
        .i_flush(i_flush), .i_sb_ready(i_sb_ready), .i_sb_full(i_sb_full),
        .i_issue_grant(i_issue_grant), .o_issue_req(req0), .o_issue_payload(pay0),
        .o_issue_src1(s1_0), .o_issue_src2(s2_0), .o_issue_dst(d_0),
        .o_issued_onehot(oh0), .o_ent_valid(ev0), .o_ent_src1(es1_0),
        .o_ent_src2(es2_0), .o_ent_dst(ed_0), .o_count(cnt0), .o_full(full0),
        .o_empty(empty0), .o_overflow(ovf0));

    ibuf_warp_queue #(.DEPTH(DEPTH), .PAYLOAD_W(PW), .TAG_W(TW), .WR_ON_ISSUE(1'b1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .i_wr_en(i_wr_en), .i_wr_payload(i_wr_payload),
        .i_wr_src1(i_wr_src1), .i_wr_src2(i_wr_src2), .i_wr_dst(i_wr_dst),
        .i_flush(i_flush), .i_sb_ready(i_sb_ready), .i_sb_full(i_sb_full),
        .i_issue_grant(i_issue_grant), .o_issue_req(req1), .o_issue_payload(pay1),
        .o_issue_src1(s1_1), .o_issue_src2(s2_1), .o_issue_dst(d_1),
        .o_issued_onehot(oh1), .o_ent_valid(ev1), .o_ent_src1(es1_1),
        .o_ent_src2(es2_1), .o_ent_dst(ed_1), .o_count(cnt1), .o_full(full1),
        .o_empty(empty1), .o_overflow(ovf1));

    function automatic logic [PW-1:0] pl(int k);
        return 48'hC0DE_0000_0000 + 48'(k);
    endfunction
    function automatic logic [TW-1:0] t1(int k);
        return {1'b1, 5'(k)};
    endfunction
    function automatic logic [TW-1:0] t2(int k);
        return {1'b1, 5'(k + 8)};
    endfunction
    function automatic logic [TW-1:0] td(int k);
        return {1'b0, 5'(k + 16)};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wr(input logic en, input int k);
        i_wr_en      = en;
        i_wr_payload = en ? pl(k) : '0;
        i_wr_src1    = en ? t1(k) : '0;
        i_wr_src2    = en ? t2(k) : '0;
        i_wr_dst     = en ? td(k) : '0;
    endtask

    task automatic push_both(input logic [DEPTH-1:0] oh, input int k);
        exp_t e;
        e.oh  = oh;
        e.pay = pl(k);
        q0.push_back(e);
        q1.push_back(e);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " dut0 count"}, 64'(cnt0), 0);
        chk({tag, " dut1 count"}, 64'(cnt1), 0);
        chk({tag, " dut0 empty"}, 64'(empty0), 1);
        chk({tag, " dut1 empty"}, 64'(empty1), 1);
        chk({tag, " dut0 full"}, 64'(full0), 0);
        chk({tag, " dut0 issue_req"}, 64'(req0), 0);
        chk({tag, " dut1 issue_req"}, 64'(req1), 0);
        chk({tag, " dut0 onehot"}, 64'(oh0), 0);
        chk({tag, " dut0 payload"}, 64'(pay0), 0);
        chk({tag, " dut1 payload"}, 64'(pay1), 0);
        chk({tag, " dut0 src1"}, 64'(s1_0), 0);
        chk({tag, " dut0 dst"}, 64'(d_0), 0);
        chk({tag, " dut0 ent_valid"}, 64'(ev0), 0);
        chk({tag, " dut1 ent_valid"}, 64'(ev1), 0);
        chk({tag, " dut0 ent_src1"}, 64'(es1_0), 0);
        chk({tag, " dut1 ent_dst"}, 64'(ed_1), 0);
        chk({tag, " dut0 overflow"}, 64'(ovf0), 0);
        chk({tag, " dut1 overflow"}, 64'(ovf1), 0);
    endtask

    // Monitor: every fired issue must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            exp_t e;
            if (req0 && i_issue_grant) begin
                if (q0.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL dut0 unexpected issue: onehot %0h payload %0h expected none", oh0, pay0);
                end else begin
                    e = q0.pop_front();
                    chk("dut0 issue onehot", 64'(oh0), 64'(e.oh));
                    chk("dut0 issue payload", 64'(pay0), 64'(e.pay));
                end
            end else begin
                chk("dut0 idle onehot", 64'(oh0), 0);
            end
            if (req1 && i_issue_grant) begin
                if (q1.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL dut1 unexpected issue: onehot %0h payload %0h expected none", oh1, pay1);
                end else begin
                    e = q1.pop_front();
                    chk("dut1 issue onehot", 64'(oh1), 64'(e.oh));
                    chk("dut1 issue payload", 64'(pay1), 64'(e.pay));
                end
            end else begin
                chk("dut1 idle onehot", 64'(oh1), 0);
            end
        end
    end

    initial begin
        #1 rst_n = 1'b0;
        #2;
        chk_reset("reset");
        rst_n = 1'b1;
        tick();

        // Fill with A..D, nothing ready.
        for (int k = 0; k < 4; k++) begin
            set_wr(1'b1, k);
            tick();
        end
        set_wr(1'b0, 0);
        #1;
        chk("fill dut0 count", 64'(cnt0), 4);
        chk("fill dut1 count", 64'(cnt1), 4);
        chk("fill dut0 full", 64'(full0), 1);
        chk("fill dut0 ent_valid", 64'(ev0), 64'hF);
        chk("fill dut1 ent_valid", 64'(ev1), 64'hF);
        chk("fill dut0 issue_req", 64'(req0), 0);
        chk("fill dut0 ent_src1[3]", 64'(es1_0[3*TW +: TW]), 64'(t1(3)));
        chk("fill dut0 ent_dst[0]", 64'(ed_0[0 +: TW]), 64'(td(0)));

        // B and C become ready; B (oldest ready) issues.
        i_sb_ready = 4'b0110;
        tick();
        i_sb_ready = 4'b0000;
        push_both(4'b0010, 1);
        i_issue_grant = 1'b1;
        #1;
        chk("B issue_req", 64'(req0), 1);
        chk("B onehot", 64'(oh0), 64'b0010);
        chk("B issue_src1", 64'(s1_0), 64'(t1(1)));
        chk("B issue_src2", 64'(s2_1), 64'(t2(1)));
        tick();
        i_issue_grant = 1'b0;
        #1;
        chk("post-B dut0 count", 64'(cnt0), 3);
        chk("post-B dut1 ent_valid", 64'(ev1), 64'b0111);
        chk("post-B ent_src1[0]", 64'(es1_0[0 +: TW]), 64'(t1(0)));
        chk("post-B ent_src1[1]", 64'(es1_0[1*TW +: TW]), 64'(t1(2)));
        chk("post-B ent_src1[2]", 64'(es1_0[2*TW +: TW]), 64'(t1(3)));
        chk("post-B issue_req", 64'(req0), 1);
        chk("post-B selects C", 64'(pay0), 64'(pl(2)));
        chk("post-B no grant onehot", 64'(oh0), 0);

        // Scoreboard full blocks issue.
        i_sb_full = 1'b1;
        i_issue_grant = 1'b1;
        #1;
        chk("sb_full dut0 issue_req", 64'(req0), 0);
        chk("sb_full dut1 issue_req", 64'(req1), 0);
        chk("sb_full onehot", 64'(oh1), 0);
        tick();
        i_sb_full = 1'b0;
        i_issue_grant = 1'b0;
        #1;
        chk("sb_full count kept", 64'(cnt0), 3);

        // Write E and mark A ready in the same cycle -> full, A selectable.
        set_wr(1'b1, 4);
        i_sb_ready = 4'b0001;
        tick();
        set_wr(1'b0, 0);
        i_sb_ready = 4'b0000;
        #1;
        chk("E dut0 count", 64'(cnt0), 4);
        chk("E dut1 full", 64'(full1), 1);
        chk("E selects A", 64'(pay0), 64'(pl(0)));

        // Full + issue + write F: the two modes diverge.
        set_wr(1'b1, 5);
        i_issue_grant = 1'b1;
        push_both(4'b0001, 0);
        #1;
        chk("F cycle onehot", 64'(oh1), 64'b0001);
        tick();
        set_wr(1'b0, 0);
        i_issue_grant = 1'b0;
        #1;
        chk("F dut0 count", 64'(cnt0), 3);
        chk("F dut0 overflow", 64'(ovf0), 1);
        chk("F dut0 ent_valid", 64'(ev0), 64'b0111);
        chk("F dut1 count", 64'(cnt1), 4);
        chk("F dut1 overflow", 64'(ovf1), 0);
        chk("F dut1 ent_src1[3]", 64'(es1_1[3*TW +: TW]), 64'(t1(5)));
        chk("F dut1 ent_src1[2]", 64'(es1_1[2*TW +: TW]), 64'(t1(4)));
        chk("F dut1 ent_src1[0]", 64'(es1_1[0 +: TW]), 64'(t1(2)));
        chk("F dut0 selects C", 64'(pay0), 64'(pl(2)));

        // C issues; D then E (never ready) remain.
        i_issue_grant = 1'b1;
        push_both(4'b0001, 2);
        tick();
        i_issue_grant = 1'b0;
        #1;
        chk("C dut0 count", 64'(cnt0), 2);
        chk("C dut1 count", 64'(cnt1), 3);
        chk("C dut0 issue_req", 64'(req0), 0);
        chk("C dut1 issue_req", 64'(req1), 0);
        chk("C idle shows entry0", 64'(pay1), 64'(pl(3)));

        // Make D ready, then flush with write and grant.
        i_sb_ready = 4'b0001;
        tick();
        i_sb_ready = 4'b0000;
        #1;
        chk("pre-flush issue_req", 64'(req1), 1);
        i_flush = 1'b1;
        set_wr(1'b1, 6);
        i_issue_grant = 1'b1;
        #1;
        chk("flush dut0 issue_req", 64'(req0), 0);
        chk("flush dut1 issue_req", 64'(req1), 0);
        chk("flush onehot", 64'(oh1), 0);
        tick();
        i_flush = 1'b0;
        set_wr(1'b0, 0);
        i_issue_grant = 1'b0;
        #1;
        chk("post-flush dut0 count", 64'(cnt0), 0);
        chk("post-flush dut1 count", 64'(cnt1), 0);
        chk("post-flush dut1 empty", 64'(empty1), 1);
        chk("post-flush dut0 ent_valid", 64'(ev0), 0);
        chk("post-flush dut0 overflow", 64'(ovf0), 1);
        chk("post-flush dut1 overflow", 64'(ovf1), 0);

        // Write-to-issue latency, then simultaneous write and issue.
        set_wr(1'b1, 7);
        tick();
        set_wr(1'b0, 0);
        #1;
        chk("lat count", 64'(cnt0), 1);
        chk("lat req after write", 64'(req0), 0);
        i_sb_ready = 4'b0001;
        tick();
        i_sb_ready = 4'b0000;
        #1;
        chk("lat req after ready", 64'(req0), 1);
        chk("lat payload", 64'(pay1), 64'(pl(7)));
        push_both(4'b0001, 7);
        i_issue_grant = 1'b1;
        set_wr(1'b1, 8);
        tick();
        i_issue_grant = 1'b0;
        set_wr(1'b0, 0);
        #1;
        chk("wr+issue dut0 count", 64'(cnt0), 1);
        chk("wr+issue dut1 count", 64'(cnt1), 1);
        chk("wr+issue ent_src1[0]", 64'(es1_0[0 +: TW]), 64'(t1(8)));
        chk("wr+issue issue_req", 64'(req0), 0);
        chk("wr+issue ent_valid", 64'(ev1), 64'b0001);

        // Async reset mid-stream with two entries.
        set_wr(1'b1, 9);
        i_sb_ready = 4'b0001;
        tick();
        set_wr(1'b0, 0);
        i_sb_ready = 4'b0000;
        #1;
        chk("pre-rst count", 64'(cnt0), 2);
        chk("pre-rst issue_req", 64'(req0), 1);
        chk("pre-rst payload", 64'(pay0), 64'(pl(8)));
        #1 rst_n = 1'b0;
        #1;
        chk_reset("async reset");
        tick();
        rst_n = 1'b1;
        tick();
        tick();

        chk("dut0 pending issues", 64'(q0.size()), 0);
        chk("dut1 pending issues", 64'(q1.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
